lcd_score_controller: RTL and testbench
=======================================

// Module: lcd_score_controller
// PURPOSE
//   Write-only sequencer for the DE2-115 HD44780 character LCD: runs power-on init, then shows the
//   two Pong scores as "dd:dd" on line 1 and refreshes on request. It sits beside GameLogic and is
//   clocked by clk_vga. Top level drives LCD_DATA from lcd_data; LCD_EN/RS/RW/ON come from this block.
// PARAMETERS
//   T_POWER  375000  power-up wait before first command, cycles (15 ms @ 25 MHz)
//   T_SETUP  2       RS/data stable before EN rises, cycles
//   T_EN     12      EN high width, cycles
//   T_HOLD   2       RS/data held after EN falls, cycles
//   T_CMD    1000    post-write wait for every byte except clear, cycles (40 us)
//   T_CLEAR  41000   post-write wait after 0x01 clear, cycles (1.64 ms)
// PORTS
//   clk          in   1  system clock (clk_vga)
//   rst          in   1  synchronous reset, active-low
//   score_left   in   4  left score, 0..15
//   score_right  in   4  right score, 0..15
//   update       in   1  single-cycle refresh request
//   busy         out  1  high while init or refresh is in progress
//   lcd_data     out  8  byte to LCD_DATA
//   lcd_en       out  1  LCD enable strobe
//   lcd_rs       out  1  0 = command, 1 = data
//   lcd_rw       out  1  constant 0 (write only)
//   lcd_on       out  1  LCD power
// BEHAVIOUR
// - Reset (rst==0 at posedge):
//   - Outputs: lcd_data=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_on=0, busy=1.
//   - Pending flag cleared; FSM -> PWR_WAIT; all counters 0.
//   - Reset mid-byte or mid-wait aborts at once; the full T_POWER wait restarts.
// - lcd_on=1 from the first cycle after reset deasserts.
// - FSM states:
//   - PWR_WAIT: T_POWER cycles -> INIT.
//   - INIT: commands 0x38, 0x0C, 0x01, 0x06 (RS=0) -> REFRESH.
//   - REFRESH: latch scores; write 0x85 (RS=0), then 5 data bytes (RS=1) -> IDLE.
//   - IDLE: busy=0; update -> REFRESH.
// - Byte write, one sub-sequence per byte:
//   - SETUP: T_SETUP cycles, EN=0, RS/data valid.
//   - STROBE: T_EN cycles, EN=1.
//   - HOLD: T_HOLD cycles, EN=0, data unchanged.
//   - WAIT: T_CMD cycles, or T_CLEAR after 0x01.
//   - Byte period = T_SETUP+T_EN+T_HOLD+wait. RS/data change only at the start of SETUP.
// - Score encoding, per score s (4-bit):
//   - tens = (s>=10) ? 0x31 : 0x20 (blank); ones = 0x30 + (s>=10 ? s-10 : s).
//   - Data order: tensL, onesL, 0x3A ':', tensR, onesR.
// - Scores are latched once, on the cycle REFRESH is entered. Later input changes do not affect
//   the refresh in progress.
// - Pending request:
//   - update while busy=1 (any state, including init) sets pending; multiple updates collapse to one.
//   - At the end of REFRESH with pending=1: clear pending and re-enter REFRESH directly. busy stays 1.
//   - update in IDLE goes straight to REFRESH; busy=1 the next cycle.
//   - update on the same cycle a refresh completes also sets pending, so it is not lost.
// - busy falls in the cycle after the last WAIT of a refresh with pending=0.
// CONFIGURATION
//   LCD_BANNER_EN defined:
//     - After INIT, before the first REFRESH only: write 0xC6 (RS=0), then 0x50 0x4F 0x4E 0x47
//       ("PONG", RS=1) to line 2.
//     - Not repeated on later refreshes.
//   LCD_BANNER_EN undefined: no banner state; line 2 stays blank after clear.
// TESTING (bench params: T_POWER=20 T_SETUP=1 T_EN=2 T_HOLD=1 T_CMD=4 T_CLEAR=10)
//   1. Release reset with scores 0/0.
//      -> No EN for 20 cycles; then bytes RS=0 38,0C,01,06,85 and RS=1 20,30,3A,20,30.
//      -> busy=0 afterwards.
//   2. In IDLE, L=12, R=7, pulse update -> busy=1 next cycle; bytes 85 then 31,32,3A,20,37.
//   3. During refresh, pulse update twice, changing scores to L=3 then L=4 (R=0).
//      -> Exactly one extra refresh, data 20,34,3A,20,30.
//   4. Assert rst while lcd_en=1 -> next cycle lcd_en=0, lcd_data=0, lcd_on=0.
//      -> After release, first EN only after 20 more cycles.
//   5. Timing monitor -> every EN pulse exactly 2 cycles high.
//      -> After 0x01, the next EN rises no earlier than 1+10+1 cycles after its EN falls.
//      -> data/RS stable whenever EN=1.
//   6. With LCD_BANNER_EN -> C6,50,4F,4E,47 between 06 and the first 85; absent on a later update.

Source files
------------

// File: rtl/lcd_score_controller.sv
// Write-only HD44780 sequencer: power-up wait, init commands, then "dd:dd" scores on line 1.
// Optional feature: define LCD_BANNER_EN to write "PONG" to line 2 once, after init.
module lcd_score_controller #(
    parameter int unsigned T_POWER = 375000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_CMD   = 1000,
    parameter int unsigned T_CLEAR = 41000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] score_left_i,
    input  logic [3:0] score_right_i,
    input  logic       update_i,
    output logic       busy_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_en_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_on_o
);

    localparam int unsigned MaxT = (T_POWER > T_CLEAR) ? T_POWER : T_CLEAR;
    localparam int unsigned CntW = $clog2(MaxT + 1);

    localparam logic [CntW-1:0] PowerLast = CntW'(T_POWER - 1);
    localparam logic [CntW-1:0] SetupLast = CntW'(T_SETUP - 1);
    localparam logic [CntW-1:0] EnLast    = CntW'(T_EN - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(T_HOLD - 1);
    localparam logic [CntW-1:0] CmdLast   = CntW'(T_CMD - 1);
    localparam logic [CntW-1:0] ClearLast = CntW'(T_CLEAR - 1);

    typedef enum logic [2:0] {
        StPwrWait,
        StInit,
`ifdef LCD_BANNER_EN
        StBanner,
`endif
        StRefresh,
        StIdle
    } state_e;

    typedef enum logic [1:0] {PhSetup, PhStrobe, PhHold, PhWait} phase_e;

    state_e          state_q, state_d;
    phase_e          phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            pending_q, pending_d;
    logic [3:0]      left_q, left_d, right_q, right_d;
    logic [7:0]      data_q, data_d;
    logic            rs_q, rs_d, en_q, en_d, on_q, on_d, busy_q, busy_d;
    logic            start_byte;
    logic [8:0]      next_byte;

    function automatic logic [7:0] tens_char(input logic [3:0] s);
        return (s >= 4'd10) ? 8'h31 : 8'h20;
    endfunction

    function automatic logic [7:0] ones_char(input logic [3:0] s);
        return (s >= 4'd10) ? 8'h30 + {4'h0, s - 4'd10} : 8'h30 + {4'h0, s};
    endfunction

    // Returns {rs, data} for byte idx of the given sequence.
    function automatic logic [8:0] seq_byte(input state_e st, input logic [2:0] idx,
                                            input logic [3:0] l, input logic [3:0] r);
        logic [8:0] b;
        b = 9'h000;
        case (st)
            StInit: begin
                case (idx)
                    3'd0:    b = {1'b0, 8'h38};
                    3'd1:    b = {1'b0, 8'h0C};
                    3'd2:    b = {1'b0, 8'h01};
                    default: b = {1'b0, 8'h06};
                endcase
            end
`ifdef LCD_BANNER_EN
            StBanner: begin
                case (idx)
                    3'd0:    b = {1'b0, 8'hC6};
                    3'd1:    b = {1'b1, 8'h50};
                    3'd2:    b = {1'b1, 8'h4F};
                    3'd3:    b = {1'b1, 8'h4E};
                    default: b = {1'b1, 8'h47};
                endcase
            end
`endif
            StRefresh: begin
                case (idx)
                    3'd0:    b = {1'b0, 8'h85};
                    3'd1:    b = {1'b1, tens_char(l)};
                    3'd2:    b = {1'b1, ones_char(l)};
                    3'd3:    b = {1'b1, 8'h3A};
                    3'd4:    b = {1'b1, tens_char(r)};
                    default: b = {1'b1, ones_char(r)};
                endcase
            end
            default: b = 9'h000;
        endcase
        return b;
    endfunction

    function automatic logic [2:0] last_idx(input state_e st);
        case (st)
            StInit:  return 3'd3;
`ifdef LCD_BANNER_EN
            StBanner: return 3'd4;
`endif
            default: return 3'd5;
        endcase
    endfunction

    // Next-state: top-level sequence plus the per-byte SETUP/STROBE/HOLD/WAIT engine.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        left_d     = left_q;
        right_d    = right_q;
        data_d     = data_q;
        rs_d       = rs_q;
        on_d       = 1'b1;
        start_byte = 1'b0;

        if (update_i && busy_q) begin
            pending_d = 1'b1;
        end

        case (state_q)
            StPwrWait: begin
                if (cnt_q == PowerLast) begin
                    state_d    = StInit;
                    idx_d      = 3'd0;
                    phase_d    = PhSetup;
                    cnt_d      = '0;
                    start_byte = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (update_i) begin
                    state_d    = StRefresh;
                    idx_d      = 3'd0;
                    phase_d    = PhSetup;
                    cnt_d      = '0;
                    left_d     = score_left_i;
                    right_d    = score_right_i;
                    start_byte = 1'b1;
                end
            end
            default: begin
                cnt_d = cnt_q + 1'b1;
                case (phase_q)
                    PhSetup: if (cnt_q == SetupLast) begin
                        phase_d = PhStrobe;
                        cnt_d   = '0;
                    end
                    PhStrobe: if (cnt_q == EnLast) begin
                        phase_d = PhHold;
                        cnt_d   = '0;
                    end
                    PhHold: if (cnt_q == HoldLast) begin
                        phase_d = PhWait;
                        cnt_d   = '0;
                    end
                    PhWait: begin
                        // Clear needs the long wait; everything else the short one.
                        if (cnt_q == ((!rs_q && data_q == 8'h01) ? ClearLast : CmdLast)) begin
                            cnt_d   = '0;
                            phase_d = PhSetup;
                            idx_d   = idx_q + 3'd1;
                            start_byte = 1'b1;
                            if (idx_q == last_idx(state_q)) begin
                                idx_d = 3'd0;
                                if (state_q == StInit) begin
`ifdef LCD_BANNER_EN
                                    state_d = StBanner;
`else
                                    state_d = StRefresh;
                                    left_d  = score_left_i;
                                    right_d = score_right_i;
`endif
                                end else if (state_q == StRefresh
                                             && !(pending_q || update_i)) begin
                                    state_d    = StIdle;
                                    phase_d    = PhWait;
                                    start_byte = 1'b0;
                                end else begin
                                    // Banner done, or a collapsed pending refresh.
                                    if (state_q == StRefresh) begin
                                        pending_d = 1'b0;
                                    end
                                    state_d = StRefresh;
                                    left_d  = score_left_i;
                                    right_d = score_right_i;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        endcase

        next_byte = seq_byte(state_d, idx_d, left_d, right_d);
        if (start_byte) begin
            rs_d   = next_byte[8];
            data_d = next_byte[7:0];
        end
        en_d   = (phase_d == PhStrobe);
        busy_d = (state_d != StIdle);
    end

    // State and registered LCD outputs, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StPwrWait;
            phase_q   <= PhWait;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            pending_q <= 1'b0;
            left_q    <= 4'd0;
            right_q   <= 4'd0;
            data_q    <= 8'h00;
            rs_q      <= 1'b0;
            en_q      <= 1'b0;
            on_q      <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            left_q    <= left_d;
            right_q   <= right_d;
            data_q    <= data_d;
            rs_q      <= rs_d;
            en_q      <= en_d;
            on_q      <= on_d;
            busy_q    <= busy_d;
        end
    end

    assign lcd_data_o = data_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_en_o   = en_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_on_o   = on_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_lcd_score_controller.sv
// Scoreboard bench for lcd_score_controller: expected LCD bytes are queued by a text-level
// model of the display contents; a monitor pops one per EN pulse and checks strobe timing.
module tb_lcd_score_controller;

    localparam int unsigned TP  = 20;
    localparam int unsigned TS  = 1;
    localparam int unsigned TE  = 2;
    localparam int unsigned TH  = 1;
    localparam int unsigned TC  = 4;
    localparam int unsigned TCL = 10;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [3:0] sl = 4'd0, sr = 4'd0;
    logic       upd = 1'b0;
    logic       busy, en, rs, rw, on;
    logic [7:0] data;

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    lcd_score_controller #(
        .T_POWER(TP), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_CMD(TC), .T_CLEAR(TCL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .score_left_i (sl),
        .score_right_i(sr),
        .update_i     (upd),
        .busy_o       (busy),
        .lcd_data_o   (data),
        .lcd_en_o     (en),
        .lcd_rs_o     (rs),
        .lcd_rw_o     (rw),
        .lcd_on_o     (on)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: what the display should receive, from characters rather than RTL state.
    function automatic logic [7:0] tens_ch(input int s);
        return (s >= 10) ? "1" : " ";
    endfunction
    function automatic logic [7:0] ones_ch(input int s);
        return 8'("0" + (s % 10));
    endfunction
    task automatic push_cmd(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
    endtask
    task automatic push_dat(input logic [7:0] b);
        exp_q.push_back({1'b1, b});
    endtask
    task automatic push_init();
        string banner;
        banner = "PONG";
        push_cmd(8'h38); push_cmd(8'h0C); push_cmd(8'h01); push_cmd(8'h06);
`ifdef LCD_BANNER_EN
        push_cmd(8'hC6);
        for (int i = 0; i < 4; i++) push_dat(banner[i]);
`endif
    endtask
    task automatic push_refresh(input int l, input int r);
        push_cmd(8'h85);
        push_dat(tens_ch(l)); push_dat(ones_ch(l)); push_dat(":");
        push_dat(tens_ch(r)); push_dat(ones_ch(r));
    endtask

    // Monitor: pop on each EN rise; check width, stability and inter-strobe gap.
    initial begin
        logic       prev_en = 1'b0;
        logic       have_last = 1'b0;
        logic [8:0] cap = '0, last = '0, e;
        int         width = 0, gap = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                prev_en = 1'b0; have_last = 1'b0; gap = 0; width = 0;
            end else begin
                if (en && !prev_en) begin
                    if (have_last) begin
                        checks++;
                        if (!last[8] && last[7:0] == 8'h01) begin
                            if (gap != int'(TH + TCL + TS)) begin
                                failures++;
                                $display("FAIL clear_gap: got %0d expected %0d", gap, TH + TCL + TS);
                            end
                        end else if (gap < int'(TH + TC + TS)) begin
                            failures++;
                            $display("FAIL cmd_gap: got %0d expected >= %0d", gap, TH + TC + TS);
                        end
                    end
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_byte: got %0h expected none", {rs, data});
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", {23'd0, rs, data}, {23'd0, e});
                    end
                    cap = {rs, data};
                    width = 1;
                end else if (en) begin
                    width++;
                    check("stable_while_en", {23'd0, rs, data}, {23'd0, cap});
                end else if (prev_en) begin
                    check("en_width", width, TE);
                    last = cap; have_last = 1'b1; gap = 1;
                end else if (have_last) begin
                    gap++;
                end
                prev_en = en;
            end
        end
    end

    task automatic pulse();
        @(posedge clk); #1 upd = 1'b1;
        @(posedge clk); #1 upd = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < budget);
        check("busy_low_at_end", {31'd0, busy}, 32'd0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Release reset at a negedge and count cycles until the first EN.
    task automatic release_reset();
        int n = 0;
        @(negedge clk); rst_ni = 1'b1;
        do begin
            @(negedge clk); n++;
            if (n == 1) check("lcd_on_after_reset", {31'd0, on}, 32'd1);
        end while (!en && n < 200);
        checks++;
        if (n <= int'(TP) || !en) begin
            failures++;
            $display("FAIL power_wait: first EN at cycle %0d expected > %0d", n, TP);
        end
    endtask

    initial begin
        int l, r, nw;
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", {31'd0, en}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_rs", {31'd0, rs}, 32'd0);
        check("rst_rw", {31'd0, rw}, 32'd0);
        check("rst_on", {31'd0, on}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);

        // Power-up with 0/0
        push_init();
        push_refresh(0, 0);
        release_reset();
        wait_idle(2000);

        // Single refresh from idle
        sl = 4'd12; sr = 4'd7;
        push_refresh(12, 7);
        pulse();
        check("busy_next_cycle", {31'd0, busy}, 32'd1);
        wait_idle(1000);

        // Two updates during a refresh collapse into one extra refresh
        push_refresh(12, 7);
        pulse();
        repeat (8) @(posedge clk);
        #1 sl = 4'd3; sr = 4'd0;
        pulse();
        repeat (8) @(posedge clk);
        #1 sl = 4'd4;
        pulse();
        push_refresh(4, 0);
        wait_idle(1000);

        // Randomized refreshes, some with a mid-refresh update
        for (int it = 0; it < 8; it++) begin
            l = $urandom_range(0, 15); r = $urandom_range(0, 15);
            sl = 4'(l); sr = 4'(r);
            push_refresh(l, r);
            pulse();
            if ($urandom_range(0, 1) == 1) begin
                nw = $urandom_range(1, 30);
                repeat (nw) @(posedge clk);
                l = $urandom_range(0, 15); r = $urandom_range(0, 15);
                #1 sl = 4'(l); sr = 4'(r);
                pulse();
                push_refresh(l, r);
            end
            wait_idle(1000);
        end

        // Reset while EN is high
        push_refresh(int'(sl), int'(sr));
        pulse();
        nw = 0;
        do begin @(negedge clk); nw++; end while (!en && nw < 200);
        check("en_seen_before_reset", {31'd0, en}, 32'd1);
        rst_ni = 1'b0;
        @(posedge clk); #1;
        check("abort_en", {31'd0, en}, 32'd0);
        check("abort_data", {24'd0, data}, 32'd0);
        check("abort_on", {31'd0, on}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd1);
        repeat (2) @(posedge clk);
        exp_q.delete();
        l = $urandom_range(0, 15); r = $urandom_range(0, 15);
        sl = 4'(l); sr = 4'(r);
        push_init();
        push_refresh(l, r);
        release_reset();
        wait_idle(2000);

        // Later refresh after re-init carries no banner
        sl = 4'd15; sr = 4'd10;
        push_refresh(15, 10);
        pulse();
        wait_idle(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
